// File: rtl/aoi_pipe.sv
// aoi_pipe: two-stage pipelined bitwise and-or-invert datapath.
// Each transaction carries TERMS groups of INPUTS operands. The mode field picks
// AOI, AO, OAI or OA. Stage 1 reduces each group and stage 2 combines the group
// results, then optionally inverts. A counter tracks completed output handshakes.
//
// Handshake: a beat moves on a rising edge where valid && ready are both high.
// A producer holds valid and its payload stable until ready is seen.
// in_ready depends only on pipeline state, never on in_valid.
// out_valid/out_data/out_mode hold stable while out_ready is low.
module aoi_pipe #(
  parameter int WIDTH  = 8,
  parameter int TERMS  = 2,
  parameter int INPUTS = 2,
  parameter int CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      in_mode,
  input  logic [TERMS*INPUTS*WIDTH-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [1:0]                      out_mode,
  output logic [CNT_W-1:0]                txn_count
);

  // Stage-1 holding registers: one reduced value per term plus its mode.
  logic             s1_valid;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_term [TERMS];

  logic [WIDTH-1:0] s1_next [TERMS];
  logic [WIDTH-1:0] s2_next;

  logic s2_free;
  logic s1_move;
  logic in_fire;
  logic out_fire;

  // Pipeline advance: the output slot is free when empty or being drained,
  // so a full pipe can drain, shift and refill in the same cycle.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_move  = s1_valid && s2_free;
    in_ready = !rst && (!s1_valid || s2_free);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

  // First level: reduce each group's operands with AND (mode[1]=0) or OR (mode[1]=1).
  always_comb begin
    for (int t = 0; t < TERMS; t++) begin
      s1_next[t] = in_data[(t*INPUTS)*WIDTH +: WIDTH];
      for (int i = 1; i < INPUTS; i++) begin
        if (in_mode[1])
          s1_next[t] = s1_next[t] | in_data[(t*INPUTS+i)*WIDTH +: WIDTH];
        else
          s1_next[t] = s1_next[t] & in_data[(t*INPUTS+i)*WIDTH +: WIDTH];
      end
    end
  end

  // Second level: combine group results with the dual operator, then invert unless mode[0]=1.
  always_comb begin
    s2_next = s1_term[0];
    for (int t = 1; t < TERMS; t++) begin
      if (s1_mode[1])
        s2_next = s2_next & s1_term[t];
      else
        s2_next = s2_next | s1_term[t];
    end
    if (!s1_mode[0])
      s2_next = ~s2_next;
  end

  // Stage 1 register: load on input transfer, otherwise empty when it hands off to stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 2'b00;
      for (int t = 0; t < TERMS; t++)
        s1_term[t] <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_mode  <= in_mode;
      for (int t = 0; t < TERMS; t++)
        s1_term[t] <= s1_next[t];
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 / output register: capture on stage-1 hand-off, drop valid when drained with nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 2'b00;
    end else if (s1_move) begin
      out_valid <= 1'b1;
      out_data  <= s2_next;
      out_mode  <= s1_mode;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Completed output handshakes, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst)
      txn_count <= '0;
    else if (out_fire)
      txn_count <= txn_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_aoi_pipe.sv
// tb_aoi_pipe: randomized and directed checks of aoi_pipe against a bit-counting
// reference model, with a scoreboard queue of expected {mode, data} results.
module tb_aoi_pipe;

  localparam int WIDTH  = 8;
  localparam int TERMS  = 2;
  localparam int INPUTS = 2;
  localparam int CNT_W  = 4;
  localparam int DW     = TERMS*INPUTS*WIDTH;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] txn_count;

  aoi_pipe #(.WIDTH(WIDTH), .TERMS(TERMS), .INPUTS(INPUTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .txn_count(txn_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Per bit: a group term is true when all (AND) or any (OR) of its operands
  // are 1; the combined value applies the dual rule over the terms.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] m, input logic [DW-1:0] d);
    logic [WIDTH-1:0] r;
    for (int b = 0; b < WIDTH; b++) begin
      int true_terms;
      logic comb;
      true_terms = 0;
      for (int t = 0; t < TERMS; t++) begin
        int ones;
        ones = 0;
        for (int i = 0; i < INPUTS; i++)
          ones += int'(d[(t*INPUTS+i)*WIDTH + b]);
        if (m[1] ? (ones > 0) : (ones == INPUTS)) true_terms++;
      end
      comb = m[1] ? (true_terms == TERMS) : (true_terms > 0);
      r[b] = m[0] ? comb : !comb;
    end
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [WIDTH+1:0] exp_q[$];
  int               n_out = 0;
  int               cyc   = 0;
  int               fire_cyc[$];

  // Sampled mid-cycle: the handshakes seen here take effect on the next rising edge.
  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      n_out = 0;
    end else begin
      check("txn_count", 32'(txn_count), 32'(n_out % (1 << CNT_W)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[WIDTH-1:0]));
          check("out_mode", 32'(out_mode), 32'(e[WIDTH+1:WIDTH]));
        end
        n_out++;
        fire_cyc.push_back(cyc);
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_mode, model(in_mode, in_data)});
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int k = 0; k < DW; k += 32) v[k +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  logic [DW-1:0]    fixed_ops;
  logic [WIDTH-1:0] mode_exp [4];
  logic [DW-1:0]    bp_d [3];
  logic [1:0]       bp_m [3];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = rand_data();
    out_ready = 1'b1;

    // Reset held 3 cycles with in_valid high.
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h00);
      check("rst_txn_count", 32'(txn_count), 32'd0);
    end
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Four modes on fixed operands a=F0 b=FF (term 0), c=0F d=0F (term 1).
    fixed_ops   = {8'h0F, 8'h0F, 8'hFF, 8'hF0};
    mode_exp[0] = 8'h00;
    mode_exp[1] = 8'hFF;
    mode_exp[2] = 8'hF0;
    mode_exp[3] = 8'h0F;
    for (int m = 0; m < 4; m++) begin
      send(2'(m), fixed_ops);
      // Result appears two cycles after the handshake cycle.
      @(negedge clk);
      check("lat_not_yet", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_valid", 32'(out_valid), 32'd1);
      check("mode_data", 32'(out_data), 32'(mode_exp[m]));
      check("mode_out_mode", 32'(out_mode), 32'(m));
      @(posedge clk); #1;
    end
    wait_drain("modes_drain");

    // Streaming: 16 back-to-back random transactions.
    @(posedge clk); #1;
    do_reset();
    fire_cyc.delete();
    for (int k = 0; k < 16; k++)
      send(2'($urandom_range(0, 3)), rand_data());
    wait_drain("stream_drain");
    check("stream_count", 32'(fire_cyc.size()), 32'd16);
    if (fire_cyc.size() == 16)
      check("stream_rate", 32'(fire_cyc[15] - fire_cyc[0]), 32'd15);
    check("stream_txn_wrap", 32'(txn_count), 32'd0);

    // Back-pressure, then simultaneous drain/shift/fill.
    @(posedge clk); #1;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bp_d[k] = rand_data();
      bp_m[k] = 2'($urandom_range(0, 3));
    end
    send(bp_m[0], bp_d[0]);
    send(bp_m[1], bp_d[1]);
    in_valid = 1'b1;
    in_mode  = bp_m[2];
    in_data  = bp_d[2];
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_frozen", 32'(out_data), 32'(model(bp_m[0], bp_d[0])));
      check("bp_frozen_mode", 32'(out_mode), 32'(bp_m[0]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("sim_in_ready", 32'(in_ready), 32'd1);
    check("sim_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("sim_txn_count", 32'(txn_count), 32'd1);
    check("sim_next", 32'(out_data), 32'(model(bp_m[1], bp_d[1])));
    @(posedge clk); #1;
    wait_drain("bp_drain");
    check("bp_total", 32'(txn_count), 32'd3);

    // Counter wrap: 17 transactions on a 4-bit counter.
    @(posedge clk); #1;
    do_reset();
    for (int k = 0; k < 17; k++)
      send(2'($urandom_range(0, 3)), rand_data());
    wait_drain("wrap_drain");
    check("wrap_txn_count", 32'(txn_count), 32'd1);

    // Reset with two in flight and the consumer ready during reset.
    @(posedge clk); #1;
    do_reset();
    out_ready = 1'b0;
    send(2'($urandom_range(0, 3)), rand_data());
    send(2'($urandom_range(0, 3)), rand_data());
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_txn_count", 32'(txn_count), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
